// File: rtl/ahb_burst_monitor.sv
// rtl/ahb_burst_monitor.sv - passive AHB-Lite burst protocol monitor
// Tracks bursts on one slave port and reports protocol violations as coded error pulses.
module ahb_burst_monitor #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  clr,
    output logic                  err_valid,
    output logic [3:0]            err_code,
    output logic [HADDR_SIZE-1:0] err_addr,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  sticky_err,
    output logic                  burst_active,
    output logic [4:0]            beat_cnt
);
    localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              size_q, size_d, burst_q, burst_d;
    logic                    write_q, write_d;
    logic [HADDR_SIZE-1:0]   prev_addr_q, prev_addr_d;
    logic [4:0]              beat_cnt_q, beat_cnt_d, beats_total_q, beats_total_d;
    logic                    done_q, done_d;
    logic                    wait_q, wait_d;
    logic [HADDR_SIZE-1:0]   wait_addr_q, wait_addr_d;
    logic [1:0]              wait_trans_q, wait_trans_d;
    logic                    err_valid_q, err_valid_d, sticky_q, sticky_d;
    logic [3:0]              err_code_q, err_code_d;
    logic [HADDR_SIZE-1:0]   err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                    accept, is_seq, is_nonseq, idle_obs, busy_obs, in_burst, fixed;
    logic [9:0]              errs;
    logic [3:0]              code_sel;
    logic [4:0]              beat_nxt, total_new;
    logic [HADDR_SIZE-1:0]   step, incr_addr, wrap_mask, exp_addr, align_mask;

    always_comb begin
        accept    = HSEL && HREADY && HTRANS[1];
        is_seq    = (HTRANS == T_SEQ);
        is_nonseq = (HTRANS == T_NONSEQ);
        idle_obs  = HSEL && HREADY && (HTRANS == T_IDLE);
        busy_obs  = HSEL && HREADY && (HTRANS == T_BUSY);
        in_burst  = (state_q == S_BURST);
        fixed     = (beats_total_q != 5'd0);

        step       = HADDR_SIZE'(32'd1 << size_q);
        incr_addr  = prev_addr_q + step;
        wrap_mask  = HADDR_SIZE'((32'(beats_total_q) << size_q) - 32'd1);
        exp_addr   = (burst_q != 3'd0 && !burst_q[0]) ?
                     ((prev_addr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
        align_mask = HADDR_SIZE'((32'd1 << HSIZE) - 32'd1);
        beat_nxt   = (beat_cnt_q == 5'h1f) ? beat_cnt_q : beat_cnt_q + 5'd1;

        case (HBURST)
            3'd0:       total_new = 5'd1;
            3'd1:       total_new = 5'd0;
            3'd2, 3'd3: total_new = 5'd4;
            3'd4, 3'd5: total_new = 5'd8;
            default:    total_new = 5'd16;
        endcase

        errs    = '0;
        errs[1] = accept && ({29'd0, HSIZE} > 32'(MAX_SIZE));
        errs[2] = !in_burst && ((accept && is_seq && !done_q) || busy_obs);
        errs[3] = in_burst && accept && is_seq &&
                  (HSIZE != size_q || HBURST != burst_q || HWRITE != write_q);
        errs[4] = in_burst && accept && is_seq && (HADDR != exp_addr);
        errs[5] = in_burst && fixed && (idle_obs || (accept && is_nonseq));
        errs[6] = !in_burst && done_q && accept && is_seq;
        errs[7] = accept && ((HADDR & align_mask) != '0);
        errs[8] = in_burst && accept && is_seq && burst_q[0] &&
                  (HADDR[HADDR_SIZE-1:10] != prev_addr_q[HADDR_SIZE-1:10]);
        errs[9] = wait_q && (HADDR != wait_addr_q || HTRANS != wait_trans_q) &&
                  !(wait_trans_q == T_BUSY && HTRANS == T_SEQ);

        code_sel = 4'd0;
        for (int i = 9; i >= 1; i--) begin
            if (errs[i]) code_sel = 4'(i);
        end

        state_d       = state_q;
        size_d        = size_q;
        burst_d       = burst_q;
        write_d       = write_q;
        prev_addr_d   = prev_addr_q;
        beat_cnt_d    = beat_cnt_q;
        beats_total_d = beats_total_q;
        done_d        = done_q;

        // An ERROR response lets the master drop the burst, so no early-termination check follows.
        if (in_burst && HRESP && !HREADY) begin
            state_d    = S_IDLE;
            beat_cnt_d = 5'd0;
            done_d     = 1'b0;
        end else if (accept && is_nonseq) begin
            size_d        = HSIZE;
            burst_d       = HBURST;
            write_d       = HWRITE;
            prev_addr_d   = HADDR;
            beats_total_d = total_new;
            if (total_new == 5'd1) begin
                state_d    = S_IDLE;
                beat_cnt_d = 5'd0;
                done_d     = 1'b1;
            end else begin
                state_d    = S_BURST;
                beat_cnt_d = 5'd1;
                done_d     = 1'b0;
            end
        end else if (in_burst && accept && is_seq) begin
            prev_addr_d = HADDR;
            beat_cnt_d  = beat_nxt;
            if (fixed && beat_nxt == beats_total_q) begin
                state_d    = S_IDLE;
                beat_cnt_d = 5'd0;
                done_d     = 1'b1;
            end
        end else if (idle_obs) begin
            state_d    = S_IDLE;
            beat_cnt_d = 5'd0;
            done_d     = 1'b0;
        end

        wait_d       = HSEL && !HREADY && (HTRANS != T_IDLE) && !HRESP;
        wait_addr_d  = HADDR;
        wait_trans_d = HTRANS;

        err_valid_d = (errs != '0);
        err_code_d  = err_valid_d ? code_sel : err_code_q;
        err_addr_d  = err_valid_d ? HADDR : err_addr_q;
        if (clr) begin
            err_cnt_d = '0;
            sticky_d  = 1'b0;
        end else begin
            err_cnt_d = (err_valid_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
            sticky_d  = sticky_q || err_valid_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            size_q        <= '0;
            burst_q       <= '0;
            write_q       <= 1'b0;
            prev_addr_q   <= '0;
            beat_cnt_q    <= '0;
            beats_total_q <= '0;
            done_q        <= 1'b0;
            wait_q        <= 1'b0;
            wait_addr_q   <= '0;
            wait_trans_q  <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            err_addr_q    <= '0;
            err_cnt_q     <= '0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            write_q       <= write_d;
            prev_addr_q   <= prev_addr_d;
            beat_cnt_q    <= beat_cnt_d;
            beats_total_q <= beats_total_d;
            done_q        <= done_d;
            wait_q        <= wait_d;
            wait_addr_q   <= wait_addr_d;
            wait_trans_q  <= wait_trans_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            err_addr_q    <= err_addr_d;
            err_cnt_q     <= err_cnt_d;
            sticky_q      <= sticky_d;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;
    assign err_cnt      = err_cnt_q;
    assign sticky_err   = sticky_q;
    assign burst_active = (state_q == S_BURST);
    assign beat_cnt     = beat_cnt_q;
endmodule

// File: tb/tb_ahb_burst_monitor.sv
// tb/tb_ahb_burst_monitor.sv - directed self-checking bench for ahb_burst_monitor
module tb_ahb_burst_monitor;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, HRESP = 1'b0, clr = 1'b0;
    logic [15:0] HADDR = '0;
    logic [2:0]  HSIZE = '0, HBURST = '0;
    logic [1:0]  HTRANS = IDLE;

    logic        ev0, se0, ba0, ev1, se1, ba1;
    logic [3:0]  ec0, ec1;
    logic [15:0] ea0, ea1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;
    logic [4:0]  bc0, bc1;

    int n_cmp = 0;
    int n_err = 0;

    ahb_burst_monitor u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP),
        .clr(clr), .err_valid(ev0), .err_code(ec0), .err_addr(ea0), .err_cnt(cnt0),
        .sticky_err(se0), .burst_active(ba0), .beat_cnt(bc0)
    );

    ahb_burst_monitor #(.ERR_CNT_W(2)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP),
        .clr(clr), .err_valid(ev1), .err_code(ec1), .err_addr(ea1), .err_cnt(cnt1),
        .sticky_err(se1), .burst_active(ba1), .beat_cnt(bc1)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] tr, input logic [15:0] a, input logic [2:0] sz,
                       input logic [2:0] bu);
        HSEL = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HWRITE = 1'b0;
        HTRANS = tr; HADDR = a; HSIZE = sz; HBURST = bu;
        @(posedge HCLK); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        clr = 1'b0;
    endtask

    initial begin
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk("rst_err_valid", ev0, 0);
        chk("rst_err_cnt", cnt0, 0);
        chk("rst_sticky", se0, 0);
        chk("rst_burst_active", ba0, 0);
        chk("rst_beat_cnt", bc0, 0);

        // reset in the middle of an INCR4
        bus(NONSEQ, 16'h0100, 3'd2, INCR4);
        bus(SEQ,    16'h0104, 3'd2, INCR4);
        chk("mid_burst_active", ba0, 1);
        chk("mid_beat_cnt", bc0, 2);
        HRESET = 1'b1;
        #2;
        chk("async_burst_active", ba0, 0);
        chk("async_beat_cnt", bc0, 0);
        HSEL = 1'b0; HTRANS = IDLE;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        chk("post_rst_err_valid", ev0, 0);
        chk("post_rst_err_cnt", cnt0, 0);

        // legal WRAP4 word burst
        bus(NONSEQ, 16'h0038, 3'd2, WRAP4);
        chk("wrap_b1_ev", ev0, 0);
        bus(SEQ, 16'h003C, 3'd2, WRAP4);
        chk("wrap_b2_ev", ev0, 0);
        bus(SEQ, 16'h0030, 3'd2, WRAP4);
        chk("wrap_b3_ev", ev0, 0);
        chk("wrap_b3_active", ba0, 1);
        bus(SEQ, 16'h0034, 3'd2, WRAP4);
        chk("wrap_b4_ev", ev0, 0);
        chk("wrap_b4_active", ba0, 0);
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        chk("wrap_cnt", cnt0, 0);

        // bad wrap address, then finish the burst legally
        bus(NONSEQ, 16'h0038, 3'd2, WRAP4);
        bus(SEQ, 16'h0040, 3'd2, WRAP4);
        chk("badwrap_ev", ev0, 1);
        chk("badwrap_code", ec0, 4);
        chk("badwrap_addr", ea0, 16'h0040);
        chk("badwrap_cnt", cnt0, 1);
        bus(SEQ, 16'h0044, 3'd2, WRAP4);
        chk("badwrap_b3_ev", ev0, 0);
        bus(SEQ, 16'h0048, 3'd2, WRAP4);
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        chk("badwrap_end_cnt", cnt0, 1);
        do_clr();
        chk("clr1_cnt", cnt0, 0);
        chk("clr1_sticky", se0, 0);

        // early termination of INCR8 halfword, then overrun of INCR4
        bus(NONSEQ, 16'h0080, 3'd1, INCR8);
        bus(SEQ, 16'h0082, 3'd1, INCR8);
        bus(SEQ, 16'h0084, 3'd1, INCR8);
        bus(NONSEQ, 16'h0100, 3'd2, INCR4);
        chk("early_ev", ev0, 1);
        chk("early_code", ec0, 5);
        chk("early_addr", ea0, 16'h0100);
        chk("restart_beat_cnt", bc0, 1);
        bus(SEQ, 16'h0104, 3'd2, INCR4);
        bus(SEQ, 16'h0108, 3'd2, INCR4);
        bus(SEQ, 16'h010C, 3'd2, INCR4);
        chk("incr4_done_active", ba0, 0);
        bus(SEQ, 16'h0110, 3'd2, INCR4);
        chk("overrun_code", ec0, 6);
        chk("overrun_cnt", cnt0, 2);
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        chk("pulse_width", ev0, 0);
        chk("sticky_held", se0, 1);
        do_clr();
        chk("clr2_cnt", cnt0, 0);
        chk("clr2_sticky", se0, 0);

        // multi-error priority: oversize and misaligned together
        bus(NONSEQ, 16'h0002, 3'd3, SINGLE);
        chk("prio_code", ec0, 1);
        chk("prio_cnt", cnt0, 1);

        // address change during a wait state
        HSEL = 1'b1; HREADY = 1'b0; HTRANS = NONSEQ; HADDR = 16'h0200;
        HSIZE = 3'd2; HBURST = SINGLE;
        @(posedge HCLK); #1;
        chk("wait_no_ev", ev0, 0);
        bus(NONSEQ, 16'h0204, 3'd2, SINGLE);
        chk("wait_code", ec0, 9);
        chk("wait_addr", ea0, 16'h0204);
        chk("wait_cnt", cnt0, 2);

        // SEQ with no burst open
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        bus(SEQ, 16'h0300, 3'd2, INCR);
        chk("seq_idle_code", ec0, 2);

        // INCR crossing a 1KB boundary, then an unbounded INCR ended by IDLE
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        bus(NONSEQ, 16'h03FC, 3'd2, INCR);
        bus(SEQ, 16'h0400, 3'd2, INCR);
        chk("kb_code", ec0, 8);
        chk("kb_cnt", cnt0, 4);
        bus(IDLE, 16'h0000, 3'd2, SINGLE);
        chk("incr_idle_ev", ev0, 0);
        chk("incr_idle_active", ba0, 0);

        // counter saturation on the 2-bit instance
        do_clr();
        for (int i = 0; i < 5; i++) bus(NONSEQ, 16'h0001, 3'd2, SINGLE);
        chk("sat_code", ec1, 7);
        chk("sat_cnt8", cnt0, 5);
        chk("sat_cnt2", cnt1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_burst_monitor.md
Name: ahb_burst_monitor

Overview:
- Synthesizable, parametrised AHB-Lite protocol monitor that attaches passively to one slave port.
- Tracks every burst cycle by cycle and checks transfer-size legality, alignment, control stability, address sequencing (incrementing and wrapping), beat count, 1KB boundary and wait-state stability.
- Reports each violation as a registered error pulse with a code and address, and keeps a saturating error count.
- Successor to the simulation-only property checker; usable in FPGA/emulation and alongside the slave in the testbench.

Parameters:
- HADDR_SIZE, 16, address width (minimum 11).
- HDATA_SIZE, 32, data bus width (8..1024, power of two); sets the maximum legal HSIZE.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  address.
- HWRITE  in  1  transfer direction.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  in  1  bus ready.
- HRESP  in  1  slave response; 1 = ERROR.
- clr  in  1  synchronous clear of err_cnt and sticky_err.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  4  code of the reported error.
- err_addr  out  HADDR_SIZE  HADDR of the offending cycle.
- err_cnt  out  ERR_CNT_W  saturating count of error cycles.
- sticky_err  out  1  set on first error; held until clr.
- burst_active  out  1  monitor is in the BURST state.
- beat_cnt  out  5  beats accepted in the current burst.

Behaviour:
- Reset: HRESET high clears all outputs and all state to 0 immediately (asynchronously); FSM goes to IDLE. No error is reported for a burst that was in progress when reset asserted.
- Acceptance: an address phase is accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ. All checks evaluate at that edge.
- Latency: err_valid, err_code and err_addr are registered and appear 1 cycle after the offending edge.
- Multiple errors in one cycle: the lowest code is reported; err_cnt increments by 1 only.
- err_cnt saturates at all-ones. clr has priority over an increment in the same cycle.

FSM:
- IDLE -> BURST on an accepted NONSEQ.
  - On entry, latch HSIZE, HBURST, HWRITE and HADDR.
  - Set beat_cnt=1.
  - Set beats_total: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=unbounded.
- BURST -> IDLE:
  - when beat_cnt reaches beats_total, or
  - when an IDLE or NONSEQ is accepted/observed while in BURST, or
  - when HRESP=1 and HREADY=0 (ERROR first cycle); the master may abandon the burst without an error being flagged.
- A NONSEQ in BURST restarts tracking in the same cycle.
- BUSY never advances the beat count or the expected address.

Error codes:
1. HSIZE > log2(HDATA_SIZE/8).
2. SEQ or BUSY (with HSEL=1) while in IDLE.
3. SEQ with HSIZE, HBURST or HWRITE differing from the latched values.
4. SEQ address differs from the expected address.
   - Incrementing: prev + 2^HSIZE.
   - Wrapping: with W = beats_total * 2^HSIZE, expected = (prev & ~(W-1)) | ((prev + 2^HSIZE) & (W-1)).
5. Early termination: IDLE or NONSEQ while beat_cnt < beats_total for a fixed-length burst, with no preceding ERROR response.
6. Overrun: SEQ accepted after beats_total beats. This is flagged even though the FSM is already back in IDLE; code 6 takes precedence over code 2 for this cycle.
7. Misaligned: HADDR is not a multiple of 2^HSIZE.
8. An INCR/INCRx SEQ beat crosses a 1KB boundary (HADDR[10] differs from prev[10] while the upper bits are equal or incremented).
9. Wait-state change: the previous cycle had HSEL=1, HREADY=0 and HTRANS non-IDLE, and HADDR or HTRANS changed. Exception: BUSY->SEQ is legal.

beat_cnt behaviour:
- Increments on each accepted SEQ in BURST.
- Clears to 0 on return to IDLE.

Test Plan:
- Reset mid-burst: INCR4 at 0x0100, assert HRESET after beat 2 -> burst_active=0, beat_cnt=0, err_valid never pulses, err_cnt=0.
- Legal WRAP4 word burst: 0x0038, 0x003C, 0x0030, 0x0034 -> no err_valid; burst_active falls the cycle after beat 4.
- Bad wrap: WRAP4 word at 0x0038 with second beat 0x0040 -> err_valid=1 one cycle later, err_code=4, err_addr=0x0040, err_cnt=1.
- Early termination and overrun:
  - INCR8 halfword with NONSEQ after 3 beats -> err_code=5.
  - INCR4 with a fifth SEQ -> err_code=6.
  - err_cnt=2; sticky_err=1 until clr, then err_cnt=0.
- Multi-error priority: HDATA_SIZE=32, NONSEQ HSIZE=3 at address 0x0002 -> err_code=1 only, err_cnt increments by 1.
- Wait-state change and saturation:
  - HREADY=0 during NONSEQ at 0x0200, HADDR changes to 0x0204 -> err_code=9.
  - With ERR_CNT_W=2, force 5 errors -> err_cnt holds 3.
